// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - register bus between the peripheral bus and the SPI slave
interface spi_slave_if #(
    parameter int DATA_WIDTH = 8
);
    logic [1:0]            addr;
    logic                  wr;
    logic [DATA_WIDTH-1:0] data_wr;
    logic [DATA_WIDTH-1:0] data_rd;

    modport master (output addr, wr, data_wr, input data_rd);
    modport slave  (input addr, wr, data_wr, output data_rd);
endinterface

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampled SPI slave, all four CPOL/CPHA modes
// Pins are synchronized to clk; transfers are full duplex, MSB first.
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    spi_slave_if.slave  bus,
    input  logic        sck,
    input  logic        mosi,
    input  logic        ss_n,
    output logic        miso,
    output logic        miso_oe,
    output logic        irq
);
    localparam int CW = $clog2(DATA_WIDTH);

    logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, ss_sync;
    logic                   sck_s, mosi_s, ss_s, sck_d, ss_d;
    logic                   active;
    logic                   cpol, cpha;
    logic [DATA_WIDTH-1:0]  tx_data, rx_data, tx_shift;
    logic [DATA_WIDTH-2:0]  rx_shift;
    logic [DATA_WIDTH-1:0]  rx_next;
    logic [CW-1:0]          bit_cnt;
    logic                   rx_full, overrun, tx_pending;
    logic                   rise, fall, lead_edge, trail_edge;
    logic                   sample_edge, shift_edge, ss_fall, last_bit;

    // The ss_n chain resets low so a master still holding ss_n low after
    // reset produces no falling edge; selection needs a real high-to-low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            ss_sync   <= '0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
        end
    end

    assign sck_s       = sck_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign ss_s        = ss_sync[SYNC_STAGES-1];
    assign rise        = sck_s & ~sck_d;
    assign fall        = ~sck_s & sck_d;
    assign lead_edge   = cpol ? fall : rise;
    assign trail_edge  = cpol ? rise : fall;
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge : trail_edge;
    assign ss_fall     = ~ss_s & ss_d;
    assign last_bit    = (bit_cnt == CW'(DATA_WIDTH - 1));
    assign rx_next     = {rx_shift, mosi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_d      <= 1'b0;
            ss_d       <= 1'b0;
            active     <= 1'b0;
            cpol       <= 1'b0;
            cpha       <= 1'b0;
            tx_data    <= '0;
            rx_data    <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            bit_cnt    <= '0;
            rx_full    <= 1'b0;
            overrun    <= 1'b0;
            tx_pending <= 1'b0;
            miso       <= 1'b0;
        end else begin
            sck_d <= sck_s;
            ss_d  <= ss_s;
            miso  <= active & tx_shift[DATA_WIDTH-1];

            // W1C clears come first so a same-cycle set below wins.
            if (bus.wr && bus.addr == 2'd1) begin
                if (bus.data_wr[0]) rx_full <= 1'b0;
                if (bus.data_wr[1]) overrun <= 1'b0;
            end

            if (ss_s) begin
                active  <= 1'b0;
                bit_cnt <= '0;
            end else if (ss_fall) begin
                active     <= 1'b1;
                tx_shift   <= tx_data;
                rx_shift   <= '0;
                bit_cnt    <= '0;
                tx_pending <= 1'b0;
            end else if (active) begin
                if (sample_edge) begin
                    rx_shift <= rx_next[DATA_WIDTH-2:0];
                    bit_cnt  <= last_bit ? '0 : bit_cnt + CW'(1);
                    if (last_bit) begin
                        rx_data <= rx_next;
                        rx_full <= 1'b1;
                        if (rx_full) overrun <= 1'b1;
                    end
                end
                if (shift_edge) begin
                    if (bit_cnt == '0) begin
                        tx_shift   <= tx_data;
                        tx_pending <= 1'b0;
                    end else begin
                        tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end

            // After the load logic so a write in the load cycle keeps TxPending set.
            if (bus.wr && bus.addr == 2'd0) begin
                cpol <= bus.data_wr[0];
                cpha <= bus.data_wr[1];
            end
            if (bus.wr && bus.addr == 2'd2) begin
                tx_data    <= bus.data_wr;
                tx_pending <= 1'b1;
            end
        end
    end

    assign miso_oe = active;
    assign irq     = rx_full;

    always_comb begin
        bus.data_rd = '0;
        case (bus.addr)
            2'd0:    bus.data_rd = DATA_WIDTH'({cpha, cpol});
            2'd1:    bus.data_rd = DATA_WIDTH'({tx_pending, active, overrun, rx_full});
            2'd2:    bus.data_rd = tx_data;
            default: bus.data_rd = rx_data;
        endcase
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed bench for spi_slave
module tb_spi_slave;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       mosi = 1'b0;
    logic       ss_n = 1'b1;
    logic       miso, miso_oe, irq;
    logic       m_cpol = 1'b0;
    logic       m_cpha = 1'b0;
    logic [7:0] rx_a, rx_b;
    int         n_cmp = 0;
    int         n_err = 0;

    spi_slave_if bus ();

    spi_slave dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .sck     (sck),
        .mosi    (mosi),
        .ss_n    (ss_n),
        .miso    (miso),
        .miso_oe (miso_oe),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [7:0] d);
        bus.addr    = a;
        bus.data_wr = d;
        bus.wr      = 1'b1;
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
    endtask

    task automatic reg_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
        bus.addr = a;
        #1;
        check(tag, bus.data_rd, exp);
    endtask

    task automatic set_mode(input logic cpol, input logic cpha);
        reg_wr(2'd0, {6'b0, cpha, cpol});
        m_cpol = cpol;
        m_cpha = cpha;
        sck    = cpol;
        wait_cyc(8);
    endtask

    task automatic ss_on();
        ss_n = 1'b0;
        wait_cyc(8);
    endtask

    task automatic ss_off();
        wait_cyc(8);
        ss_n = 1'b1;
        wait_cyc(8);
    endtask

    // Master side with an Sck half period of 8 clk cycles.
    task automatic spi_bits(input logic [7:0] mo, output logic [7:0] mi, input int nbits);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!m_cpha) begin
                mosi = mo[7-i];
                wait_cyc(8);
                sck       = ~m_cpol;
                mi[7-i]   = miso;
                wait_cyc(8);
                sck = m_cpol;
            end else begin
                sck  = ~m_cpol;
                mosi = mo[7-i];
                wait_cyc(8);
                sck     = m_cpol;
                mi[7-i] = miso;
                wait_cyc(8);
            end
        end
    endtask

    initial begin
        bus.addr    = 2'd0;
        bus.wr      = 1'b0;
        bus.data_wr = 8'h00;

        wait_cyc(3);
        check("rst_miso", {7'b0, miso}, 8'h00);
        check("rst_oe", {7'b0, miso_oe}, 8'h00);
        check("rst_irq", {7'b0, irq}, 8'h00);
        reg_chk("rst_ctrl", 2'd0, 8'h00);
        reg_chk("rst_status", 2'd1, 8'h00);
        reg_chk("rst_tx", 2'd2, 8'h00);
        reg_chk("rst_rx", 2'd3, 8'h00);
        rst_n = 1'b1;
        wait_cyc(4);

        // Mode 0 single byte
        set_mode(1'b0, 1'b0);
        reg_wr(2'd2, 8'hA5);
        reg_chk("m0_pending", 2'd1, 8'h08);
        ss_on();
        reg_chk("m0_busy", 2'd1, 8'h04);
        check("m0_oe", {7'b0, miso_oe}, 8'h01);
        spi_bits(8'h3C, rx_a, 8);
        ss_off();
        check("m0_master_rx", rx_a, 8'hA5);
        reg_chk("m0_rxdata", 2'd3, 8'h3C);
        reg_chk("m0_status", 2'd1, 8'h01);
        check("m0_irq", {7'b0, irq}, 8'h01);
        check("m0_miso_idle", {7'b0, miso}, 8'h00);
        reg_wr(2'd1, 8'h01);
        check("m0_irq_clr", {7'b0, irq}, 8'h00);

        // Modes 1..3
        for (int m = 1; m < 4; m++) begin
            logic [1:0] mv;
            mv = m[1:0];
            set_mode(mv[1], mv[0]);
            reg_chk($sformatf("mode%0d_ctrl", m), 2'd0, {6'b0, mv[0], mv[1]});
            reg_wr(2'd2, 8'h81);
            ss_on();
            spi_bits(8'h7E, rx_a, 8);
            ss_off();
            check($sformatf("mode%0d_master_rx", m), rx_a, 8'h81);
            reg_chk($sformatf("mode%0d_rxdata", m), 2'd3, 8'h7E);
            reg_chk($sformatf("mode%0d_status", m), 2'd1, 8'h01);
            reg_wr(2'd1, 8'h01);
        end

        // Back-to-back bytes, no read in between
        set_mode(1'b0, 1'b0);
        reg_wr(2'd2, 8'h5C);
        ss_on();
        spi_bits(8'h11, rx_a, 8);
        spi_bits(8'h22, rx_b, 8);
        ss_off();
        check("b2b_master_rx0", rx_a, 8'h5C);
        check("b2b_master_rx1", rx_b, 8'h5C);
        reg_chk("b2b_rxdata", 2'd3, 8'h22);
        reg_chk("b2b_status", 2'd1, 8'h03);
        check("b2b_irq", {7'b0, irq}, 8'h01);
        reg_wr(2'd1, 8'h03);
        reg_chk("b2b_status_clr", 2'd1, 8'h00);
        check("b2b_irq_clr", {7'b0, irq}, 8'h00);

        // Deselect after 5 bits, then a full byte
        ss_on();
        spi_bits(8'hFF, rx_a, 5);
        ss_off();
        reg_chk("part_rxdata", 2'd3, 8'h22);
        reg_chk("part_status", 2'd1, 8'h00);
        ss_on();
        spi_bits(8'h5A, rx_a, 8);
        ss_off();
        check("part_retx", rx_a, 8'h5C);
        reg_chk("part_full_rxdata", 2'd3, 8'h5A);
        reg_chk("part_full_status", 2'd1, 8'h01);
        reg_wr(2'd1, 8'h01);

        // W1C of RxFull landing on the byte-completion cycle
        ss_on();
        spi_bits(8'hC7, rx_a, 7);
        mosi = 1'b1;
        wait_cyc(8);
        sck = 1'b1;
        wait_cyc(2);
        reg_wr(2'd1, 8'h01);
        reg_chk("race_w1c_status", 2'd1, 8'h05);
        wait_cyc(8);
        sck = 1'b0;
        ss_off();
        reg_chk("race_w1c_rxdata", 2'd3, 8'hC7);
        reg_wr(2'd1, 8'h01);

        // TXDATA write in the Ss_n load cycle
        reg_wr(2'd2, 8'h96);
        ss_n = 1'b0;
        wait_cyc(2);
        reg_wr(2'd2, 8'hC3);
        reg_chk("race_tx_status", 2'd1, 8'h0C);
        wait_cyc(4);
        spi_bits(8'h00, rx_a, 8);
        ss_off();
        check("race_tx_old_byte", rx_a, 8'h96);
        reg_chk("race_tx_data", 2'd2, 8'hC3);
        reg_chk("race_tx_status_end", 2'd1, 8'h01);

        // Reset pulsed mid-byte with RxFull still set
        reg_wr(2'd2, 8'hF0);
        ss_on();
        spi_bits(8'hAA, rx_a, 4);
        check("mid_irq_before", {7'b0, irq}, 8'h01);
        rst_n = 1'b0;
        wait_cyc(2);
        check("mid_rst_miso", {7'b0, miso}, 8'h00);
        check("mid_rst_oe", {7'b0, miso_oe}, 8'h00);
        check("mid_rst_irq", {7'b0, irq}, 8'h00);
        reg_chk("mid_rst_status", 2'd1, 8'h00);
        reg_chk("mid_rst_tx", 2'd2, 8'h00);
        reg_chk("mid_rst_rx", 2'd3, 8'h00);
        rst_n = 1'b1;
        wait_cyc(10);
        check("mid_post_oe", {7'b0, miso_oe}, 8'h00);
        reg_chk("mid_post_status", 2'd1, 8'h00);
        ss_n = 1'b1;
        wait_cyc(8);
        reg_wr(2'd2, 8'h3C);
        ss_on();
        check("mid_resume_oe", {7'b0, miso_oe}, 8'h01);
        spi_bits(8'h96, rx_a, 8);
        ss_off();
        check("mid_resume_master_rx", rx_a, 8'h3C);
        reg_chk("mid_resume_rxdata", 2'd3, 8'h96);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
